// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU control sequencer:
//   - ALU operation codes driven on to_alu
//   - R-type funct field codes
//   - en_uc ALU class codes
//   - FSM state enum and decode result struct
//   - alu_decode(): pure class/funct -> {illegal, op, is_multi} decode
package alu_pkg;

    // Widest en_uc the decoder handles; narrower buses are zero-extended.
    localparam int UC_MAX_W = 8;

    // ALU operation codes
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    // R-type funct field codes
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;

    // en_uc ALU class codes
    localparam logic [UC_MAX_W-1:0] UC_RTYPE = UC_MAX_W'(0);
    localparam logic [UC_MAX_W-1:0] UC_ADD   = UC_MAX_W'(1);
    localparam logic [UC_MAX_W-1:0] UC_SUB   = UC_MAX_W'(2);
    localparam logic [UC_MAX_W-1:0] UC_AND   = UC_MAX_W'(3);
    localparam logic [UC_MAX_W-1:0] UC_OR    = UC_MAX_W'(4);
    localparam logic [UC_MAX_W-1:0] UC_SLT   = UC_MAX_W'(5);
    localparam logic [UC_MAX_W-1:0] UC_XOR   = UC_MAX_W'(6);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_MULTI = 2'd2
    } state_e;

    typedef struct packed {
        logic       illegal;
        logic [3:0] op;
        logic       is_multi;
    } dec_t;

    function automatic dec_t alu_decode(input logic [UC_MAX_W-1:0] en_uc,
                                        input logic [5:0]          funct);
        dec_t d;
        d.illegal  = 1'b0;
        d.op       = OP_ADD;
        d.is_multi = 1'b0;
        case (en_uc)
            UC_RTYPE: begin
                case (funct)
                    F_AND:  d.op = OP_AND;
                    F_OR:   d.op = OP_OR;
                    F_ADD:  d.op = OP_ADD;
                    F_SUB:  d.op = OP_SUB;
                    F_SLT:  d.op = OP_SLT;
                    F_XOR:  d.op = OP_XOR;
                    F_NOR:  d.op = OP_NOR;
                    F_MULT: begin d.op = OP_MULT; d.is_multi = 1'b1; end
                    F_DIV:  begin d.op = OP_DIV;  d.is_multi = 1'b1; end
                    default: begin d.op = OP_AND; d.illegal = 1'b1; end
                endcase
            end
            UC_ADD:  d.op = OP_ADD;
            UC_SUB:  d.op = OP_SUB;
            UC_AND:  d.op = OP_AND;
            UC_OR:   d.op = OP_OR;
            UC_SLT:  d.op = OP_SLT;
            UC_XOR:  d.op = OP_XOR;
            // Unknown class falls back to ADD and flags it.
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if
// Request/response bundle between the ID/EX stage and the ALU control
// sequencer.
//   master: drives in_valid, funct, en_uc, out_ready
//   slave : drives in_ready, out_valid, to_alu, illegal, busy, mc_start
interface alu_ctrl_seq_if #(
    parameter int UC_W = 3
) ();
    logic            in_valid;
    logic            in_ready;
    logic [5:0]      funct;
    logic [UC_W-1:0] en_uc;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      to_alu;
    logic            illegal;
    logic            busy;
    logic            mc_start;

    modport master (
        output in_valid, funct, en_uc, out_ready,
        input  in_ready, out_valid, to_alu, illegal, busy, mc_start
    );

    modport slave (
        input  in_valid, funct, en_uc, out_ready,
        output in_ready, out_valid, to_alu, illegal, busy, mc_start
    );
endinterface

// File: rtl/alu_decode_comb.sv
// alu_decode_comb
// Purely combinational ALU class / funct decode.
//   en_uc : ALU class from the control unit (UC_W bits)
//   funct : R-type function field
//   dec   : {illegal, op, is_multi}
module alu_decode_comb import alu_pkg::*; #(
    parameter int UC_W = 3
) (
    input  logic [UC_W-1:0] en_uc,
    input  logic [5:0]      funct,
    output dec_t            dec
);
    if (UC_W < 1 || UC_W > UC_MAX_W) begin : g_bad_uc_w
        $error("alu_decode_comb: UC_W out of range");
    end

    assign dec = alu_decode(UC_MAX_W'(en_uc), funct);
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
// Registered, handshaked ALU control decoder that also sequences the
// fixed-latency MULT/DIV unit.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : alu_ctrl_seq_if slave (request in, decoded op out, busy/mc_start)
// Parameters: UC_W (en_uc width), MUL_LAT / DIV_LAT (1..15 cycles).
module alu_ctrl_seq import alu_pkg::*; #(
    parameter int UC_W    = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic           clk,
    input  logic           rst,
    alu_ctrl_seq_if.slave  bus
);
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("alu_ctrl_seq: MUL_LAT must be 1..15");
    end
    if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div_lat
        $error("alu_ctrl_seq: DIV_LAT must be 1..15");
    end

    // Counter counts down to 0, so it is loaded with latency minus one.
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q;
    logic [3:0] op_q;
    logic       ill_q;
    logic       start_q;
    logic       in_ready;
    logic       accept;
    dec_t       dec;

    alu_decode_comb #(.UC_W(UC_W)) u_decode (
        .en_uc (bus.en_uc),
        .funct (bus.funct),
        .dec   (dec)
    );

    // Ready depends on state and out_ready only; in_valid never feeds back.
    assign in_ready = (state_q == ST_IDLE) ||
                      (state_q == ST_HOLD && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = dec.is_multi ? ST_MULTI : ST_HOLD;
            end
            ST_HOLD: begin
                // An accept in HOLD implies out_ready: drain and refill together.
                if (accept)             state_d = dec.is_multi ? ST_MULTI : ST_HOLD;
                else if (bus.out_ready) state_d = ST_IDLE;
            end
            ST_MULTI: begin
                if (cnt_q == 4'd0) state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= OP_AND;
            ill_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= accept && dec.is_multi;
            if (accept) begin
                // Result is captured once at acceptance and held until the next accept.
                op_q  <= dec.op;
                ill_q <= dec.illegal;
                if (dec.is_multi) cnt_q <= (dec.op == OP_DIV) ? DIV_CNT : MUL_CNT;
            end else if (state_q == ST_MULTI && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.busy      = (state_q == ST_MULTI);
    assign bus.mc_start  = start_q;
    assign bus.to_alu    = op_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level reference model (pending result + remaining
// multi-cycle latency).
module tb_alu_ctrl_seq;
    localparam int UC_W    = 3;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_ctrl_seq_if #(.UC_W(UC_W)) bus ();

    alu_ctrl_seq #(.UC_W(UC_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         mc_left  = 0;     // remaining busy cycles of a MULT/DIV
    bit         have_out = 1'b0;  // result waiting for the consumer
    logic [3:0] m_op     = 4'd0;
    bit         m_ill    = 1'b0;
    bit         m_start  = 1'b0;

    logic [5:0] legal_f [9] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                                6'b101010, 6'b100110, 6'b100111, 6'b011000,
                                6'b011010};

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Decode straight from the opcode tables.
    task automatic ref_decode(input logic [2:0] e, input logic [5:0] f,
                              output logic [3:0] op, output bit ill, output int lat);
        ill = 1'b0;
        lat = 0;
        case (e)
            3'd0: case (f)
                6'b100100: op = 4'd0;
                6'b100101: op = 4'd1;
                6'b100000: op = 4'd2;
                6'b100010: op = 4'd6;
                6'b101010: op = 4'd7;
                6'b100110: op = 4'd3;
                6'b100111: op = 4'd4;
                6'b011000: begin op = 4'd8; lat = MUL_LAT; end
                6'b011010: begin op = 4'd9; lat = DIV_LAT; end
                default:   begin op = 4'd0; ill = 1'b1; end
            endcase
            3'd1: op = 4'd2;
            3'd2: op = 4'd6;
            3'd3: op = 4'd0;
            3'd4: op = 4'd1;
            3'd5: op = 4'd7;
            3'd6: op = 4'd3;
            default: begin op = 4'd2; ill = 1'b1; end
        endcase
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model at posedge.
    task automatic step(input bit r, input bit iv, input logic [5:0] f,
                        input logic [2:0] e, input bit ordy);
        bit         exp_rdy, acc, ill;
        logic [3:0] op;
        int         lat;
        @(negedge clk);
        rst           = r;
        bus.in_valid  = iv;
        bus.funct     = f;
        bus.en_uc     = e;
        bus.out_ready = ordy;
        #1;
        exp_rdy = (mc_left == 0) && (!have_out || ordy);
        check("in_ready",  8'(bus.in_ready),  8'(exp_rdy));
        check("out_valid", 8'(bus.out_valid), 8'(have_out));
        check("busy",      8'(bus.busy),      8'(mc_left > 0));
        check("mc_start",  8'(bus.mc_start),  8'(m_start));
        check("to_alu",    8'(bus.to_alu),    8'(m_op));
        check("illegal",   8'(bus.illegal),   8'(m_ill));
        acc = iv && exp_rdy;
        ref_decode(e, f, op, ill, lat);
        @(posedge clk);
        if (r) begin
            mc_left = 0; have_out = 1'b0; m_op = 4'd0; m_ill = 1'b0; m_start = 1'b0;
        end else begin
            m_start = 1'b0;
            if (mc_left > 0) begin
                mc_left--;
                if (mc_left == 0) have_out = 1'b1;
            end else if (have_out && ordy) begin
                have_out = 1'b0;
            end
            if (acc) begin
                m_op  = op;
                m_ill = ill;
                if (lat > 0) begin
                    mc_left = lat; m_start = 1'b1; have_out = 1'b0;
                end else begin
                    have_out = 1'b1;
                end
            end
        end
    endtask

    // Spot check of a freshly presented result, just after the edge.
    task automatic expect_out(input string tag, input logic [3:0] op, input bit ill);
        #1;
        check({tag, "_valid"}, 8'(bus.out_valid), 8'd1);
        check({tag, "_op"},    8'(bus.to_alu),    8'(op));
        check({tag, "_ill"},   8'(bus.illegal),   8'(ill));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.funct     = 6'd0;
        bus.en_uc     = 3'd0;
        bus.out_ready = 1'b0;

        // Reset
        step(1, 0, 6'd0, 3'd0, 1);
        step(1, 0, 6'd0, 3'd0, 1);

        // SUB through R-type
        step(0, 1, 6'b100010, 3'd0, 1); expect_out("sub", 4'b0110, 0);

        // Zero-bubble stream
        step(0, 1, 6'b100100, 3'd0, 1); expect_out("s_and", 4'b0000, 0);
        step(0, 1, 6'b100101, 3'd0, 1); expect_out("s_or",  4'b0001, 0);
        step(0, 1, 6'b101010, 3'd0, 1); expect_out("s_slt", 4'b0111, 0);
        step(0, 1, 6'b100111, 3'd0, 1); expect_out("s_nor", 4'b0100, 0);
        step(0, 0, 6'd0, 3'd0, 1);

        // MULT, with a request held during busy that must not be accepted
        step(0, 1, 6'b011000, 3'd0, 1);
        for (int i = 0; i < MUL_LAT; i++) step(0, 1, 6'b100000, 3'd0, 1);
        expect_out("mult", 4'b1000, 0);
        step(0, 0, 6'd0, 3'd0, 1);

        // DIV
        step(0, 1, 6'b011010, 3'd0, 1);
        for (int i = 0; i < DIV_LAT; i++) step(0, 0, 6'd0, 3'd0, 1);
        expect_out("div", 4'b1001, 0);
        step(0, 0, 6'd0, 3'd0, 1);

        // Backpressure then drain-and-accept in one cycle
        step(0, 1, 6'd0, 3'd1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 6'd0, 3'd6, 0);
        step(0, 1, 6'd0, 3'd6, 1); expect_out("bp_new", 4'b0011, 0);
        step(0, 0, 6'd0, 3'd0, 1);

        // Illegal class and illegal funct
        step(0, 1, 6'd0, 3'b111, 1);      expect_out("uc111", 4'b0010, 1);
        step(0, 1, 6'b111111, 3'd0, 1);   expect_out("f3f",   4'b0000, 1);
        step(0, 0, 6'd0, 3'd0, 1);

        // Reset in the 2nd cycle of a DIV: pending result must vanish
        step(0, 1, 6'b011010, 3'd0, 1);
        step(0, 0, 6'd0, 3'd0, 1);
        step(1, 0, 6'd0, 3'd0, 1);
        #1;
        check("rst_busy",  8'(bus.busy),      8'd0);
        check("rst_valid", 8'(bus.out_valid), 8'd0);
        check("rst_op",    8'(bus.to_alu),    8'd0);
        check("rst_rdy",   8'(bus.in_ready),  8'd1);
        for (int i = 0; i < DIV_LAT + 2; i++) step(0, 0, 6'd0, 3'd0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] f;
            logic [2:0] e;
            f = ($urandom_range(0, 9) < 8) ? legal_f[$urandom_range(0, 8)] : 6'($urandom);
            e = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), f, e,
                 ($urandom_range(0, 9) < 7));
        end
        step(0, 0, 6'd0, 3'd0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, handshaked successor to the combinational ALU control decoder. It decodes the control unit's ALU class (`en_uc`) and the R-type `funct` field into an ALU operation code. It also sequences the multi-cycle MULT/DIV operations, holding the pipeline with `busy` until the operation's fixed latency expires. The block sits between the ID/EX boundary and the ALU/multiplier-divider datapath.

## Interface
- `UC_W`, default 3: width of `en_uc`.
- `MUL_LAT`, default 4: MULT latency in cycles; legal range 1..15.
- `DIV_LAT`, default 8: DIV latency in cycles; legal range 1..15.

One clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode request present.
- `in_ready`  out  1  block accepts a request this cycle.
- `funct`  in  6  R-type function field.
- `en_uc`  in  UC_W  ALU class from the control unit.
- `out_valid`  out  1  `to_alu` and `illegal` are valid.
- `out_ready`  in  1  consumer takes the output this cycle.
- `to_alu`  out  4  ALU operation code.
- `illegal`  out  1  unknown funct or en_uc.
- `busy`  out  1  multi-cycle operation in progress.
- `mc_start`  out  1  one-cycle pulse that starts the MULT/DIV unit.

## Operation
- ALU op codes:
  - AND=0000, OR=0001, ADD=0010, XOR=0011, NOR=0100, SUB=0110, SLT=0111.
  - MULT=1000, DIV=1001.
- `en_uc` decode:
  - 000 → R-type, decoded from `funct`.
  - 001 → ADD, 010 → SUB, 011 → AND, 100 → OR, 101 → SLT, 110 → XOR.
  - Any other value → ADD with `illegal`=1.
- R-type funct decode:
  - 100100 AND, 100101 OR, 100000 ADD, 100010 SUB.
  - 101010 SLT, 100110 XOR, 100111 NOR.
  - 011000 MULT, 011010 DIV.
  - Any other funct → AND with `illegal`=1.
- A request is accepted when `in_valid` && `in_ready`.
- FSM states:
  - **IDLE**: `in_ready`=1.
    - Accepting a single-cycle op goes to HOLD.
    - Accepting MULT/DIV goes to MULTI; the counter loads LAT−1 and `mc_start` pulses next cycle.
  - **HOLD**: `out_valid`=1 and outputs are stable.
    - `in_ready` = `out_ready`, so a new request can be accepted in the same cycle the current output drains.
    - `out_ready` && new single-cycle accept → stay in HOLD with new outputs.
    - `out_ready` && new MULT/DIV accept → MULTI.
    - `out_ready` with no accept → IDLE.
    - No `out_ready` → stay in HOLD.
  - **MULTI**: `busy`=1, `in_ready`=0, `out_valid`=0.
    - Counter decrements each cycle.
    - When the counter is 0, the next state is HOLD with `to_alu`=MULT/DIV.
- Decoded `to_alu` and `illegal` are registered at acceptance and never change while in HOLD or MULTI.
- Latency constants are 4-bit. Parameters outside 1..15 fail elaboration.

## Timing
- Reset values: state IDLE, `out_valid`=0, `to_alu`=0000, `illegal`=0, `busy`=0, `mc_start`=0, counter=0, `in_ready`=1 (combinational from IDLE).
- Single-cycle op accepted at edge N → `out_valid`=1 from edge N+1.
- MULT accepted at edge N:
  - `mc_start`=1 and `busy`=1 during cycle N+1.
  - `busy` stays high for MUL_LAT cycles.
  - `out_valid` rises at edge N+MUL_LAT+1.
- DIV behaves the same as MULT with DIV_LAT.
- LAT=1: MULTI lasts exactly one cycle.
- Back-to-back single-cycle ops with `out_ready` held high → one result per cycle, zero bubbles.
- `rst` asserted in any state, including mid-MULTI → all reset values at the next edge; any pending output is dropped.
- `rst` overrides a simultaneous accept.
- `in_ready` and `out_valid` depend only on state and `out_ready`; there is no combinational path from `in_valid`.

## Structure
- Shared package `alu_pkg`:
  - ALU op code constants.
  - Funct constants.
  - `en_uc` class constants.
  - State enum.
  - Decode function `alu_decode(en_uc, funct)`, which returns {illegal, op, is_multi}.
- Natural sub-module: `alu_decode_comb`, the purely combinational decode, instantiated by `alu_ctrl_seq`. The FSM and counter live in the top module.

## Test plan
- Reset, then `en_uc`=000, `funct`=100010, `out_ready`=1 → one edge later `to_alu`=0110, `out_valid`=1, `illegal`=0.
- Stream AND, OR, SLT, NOR across 4 consecutive cycles with `out_ready`=1 → outputs 0000, 0001, 0111, 0100 on consecutive cycles; `in_ready` never drops.
- MULT (`funct`=011000) with MUL_LAT=4 → `mc_start` pulses once; `busy` is high for 4 cycles with `in_ready`=0; then `to_alu`=1000 and `out_valid`=1. Repeat with DIV (`funct`=011010) and DIV_LAT=8.
- Backpressure: `out_ready`=0 for 3 cycles in HOLD while `in_valid`=1 → output stable, `in_ready`=0, nothing accepted; `out_ready`=1 → drain and accept in the same cycle.
- `en_uc`=111, then `en_uc`=000 with `funct`=111111 → `illegal`=1 and `to_alu`=0010; `illegal`=1 and `to_alu`=0000.
- `rst` asserted in the 2nd cycle of a DIV → next edge shows IDLE and all outputs at reset values; no `out_valid` ever appears for that DIV.
